// File: rtl/inst_mem_responder_pkg.sv
// rtl/inst_mem_responder_pkg.sv - shared fetch-interface constants for the instruction ROM responder
package inst_mem_responder_pkg;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  localparam int DEF_PC_LENGTH   = 32;
  localparam int PC_STEP         = 4;
  localparam int DEF_INST_LENGTH = 32;
  localparam int DEF_DEPTH_LOG2  = 10;

  localparam logic [DEF_INST_LENGTH-1:0] NOP_INST = '0;

endpackage

// File: rtl/inst_mem_array.sv
// rtl/inst_mem_array.sv - word array with synchronous write and combinational read port
module inst_mem_array #(
  parameter int DEPTH_LOG2 = 10,
  parameter int WIDTH      = 32
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);

  // Contents are deliberately not reset so an aborted load leaves earlier words intact.
  logic [WIDTH-1:0] mem [0:(1<<DEPTH_LOG2)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/inst_mem_responder.sv
// rtl/inst_mem_responder.sv - instruction ROM responder: streamed image load, then registered fetch
module inst_mem_responder
  import inst_mem_responder_pkg::*;
#(
  parameter int                     PC_LENGTH   = DEF_PC_LENGTH,
  parameter int                     INST_LENGTH = DEF_INST_LENGTH,
  parameter int                     DEPTH_LOG2  = DEF_DEPTH_LOG2,
  parameter logic [INST_LENGTH-1:0] NOP_WORD    = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   romCe,
  input  logic [PC_LENGTH-1:0]   pc,
  output logic [INST_LENGTH-1:0] inst,
  output logic                   instValid,
  output logic                   addrErr,
  input  logic                   ldValid,
  input  logic [INST_LENGTH-1:0] ldData,
  input  logic                   ldLast,
  output logic                   ldReady,
  output logic [DEPTH_LOG2:0]    ldCount,
  output logic                   running
);

  localparam logic [0:0] LOAD = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] LAST_IDX = {1'b0, {DEPTH_LOG2{1'b1}}};

  logic [0:0]             state;
  logic                   ld_fire;
  logic                   last_slot;
  logic                   misaligned;
  logic                   out_of_range;
  logic [DEPTH_LOG2-1:0]  ridx;
  logic [INST_LENGTH-1:0] rdata;

  assign ldReady      = (state == LOAD);
  assign running      = (state == RUN);
  assign ld_fire      = ldValid && ldReady;
  assign last_slot    = (ldCount == LAST_IDX);
  assign ridx         = pc[DEPTH_LOG2+1:2];
  assign misaligned   = (pc[1:0] != 2'b00);
  assign out_of_range = ((pc >> (DEPTH_LOG2 + 2)) != '0);

  inst_mem_array #(
    .DEPTH_LOG2(DEPTH_LOG2),
    .WIDTH     (INST_LENGTH)
  ) u_array (
    .clk  (clk),
    .we   (ld_fire),
    .waddr(ldCount[DEPTH_LOG2-1:0]),
    .wdata(ldData),
    .raddr(ridx),
    .rdata(rdata)
  );

  // Leaving LOAD on the final slot means ldCount stops at DEPTH and never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= LOAD;
      ldCount <= '0;
    end else if (ld_fire) begin
      ldCount <= ldCount + 1'b1;
      if (ldLast || last_slot) begin
        state <= RUN;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst      <= NOP_WORD;
      instValid <= DISABLE;
      addrErr   <= DISABLE;
    end else if ((state == RUN) && romCe) begin
      if (misaligned || out_of_range) begin
        inst      <= NOP_WORD;
        instValid <= DISABLE;
        addrErr   <= ENABLE;
      end else begin
        inst      <= rdata;
        instValid <= ENABLE;
        addrErr   <= DISABLE;
      end
    end else begin
      inst      <= NOP_WORD;
      instValid <= DISABLE;
      addrErr   <= DISABLE;
    end
  end

endmodule
